xadc_conv_sequencer: RTL
========================

// Module: xadc_conv_sequencer
// PURPOSE
//  Bridges the speckle sensor controller's ADC request to the XADC primitive.
//  Turns a one-cycle o_adc_trigger pulse into a CONVST pulse and waits for EOC.
//  Reads the result register over the DRP and returns NB_DATA bits plus a done pulse.
//  Sits between speckle_sensor_controller (i_adc_val/i_adc_done) and the adc core.
// PARAMETERS
//  NB_DATA       12      result width; taken from DRP word bits [15 -: NB_DATA]
//  DRP_ADDR      7'h16   DRP address read (VAUX6 status register)
//  CONVST_WIDTH  4       cycles o_convst is held high (>=1)
//  TIMEOUT       1024    max cycles spent in WAIT_EOC or WAIT_DRDY (>=2)
// PORTS
//  clk          in   1        system clock (125 MHz)
//  rst          in   1        asynchronous, active-high reset
//  i_trigger    in   1        conversion request pulse from controller
//  o_busy       out  1        high in every state except IDLE
//  o_adc_val    out  NB_DATA  last good result; held until next good read
//  o_adc_done   out  1        1-cycle pulse at end of every accepted request
//  o_timeout    out  1        1-cycle pulse coincident with o_adc_done on timeout
//  o_overrun    out  1        1-cycle pulse when i_trigger arrives while busy
//  o_convst     out  1        to XADC convst_in
//  i_eoc        in   1        from XADC eoc_out
//  o_den        out  1        DRP enable, 1-cycle pulse
//  o_daddr      out  7        DRP address, constant DRP_ADDR
//  o_dwe        out  1        DRP write enable, constant 0
//  i_drdy       in   1        DRP data ready
//  i_do         in   16       DRP read data
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, except o_daddr=DRP_ADDR. Counters cleared.
//    rst mid-operation aborts immediately; no done pulse is produced.
//  - All outputs are registered. The FSM advances on posedge clk.
//  - IDLE: i_trigger=1 -> CONV. o_convst rises the next cycle.
//  - CONV: o_convst=1 for exactly CONVST_WIDTH cycles, then WAIT_EOC.
//    An i_eoc seen during CONV sets eoc_seen.
//  - WAIT_EOC: i_eoc=1 or eoc_seen -> READ. Otherwise timeout.
//  - READ: o_den=1 for one cycle, then WAIT_DRDY.
//    i_drdy in the READ cycle is ignored.
//  - WAIT_DRDY: i_drdy=1 -> o_adc_val<=i_do[15 -: NB_DATA]; o_adc_done=1 next cycle.
//    Then IDLE.
//  - Latency, trigger at edge k with EOC and DRDY instantaneous:
//    done at k+CONVST_WIDTH+4.
//  - Timeout: a cycle counter runs in WAIT_EOC/WAIT_DRDY and clears on state entry.
//    Reaching TIMEOUT cycles -> o_adc_done=1 and o_timeout=1 for one cycle,
//    o_adc_val unchanged, then IDLE.
//  - i_trigger while o_busy=1: ignored (not queued), o_overrun pulses one cycle.
//    i_trigger in the same cycle as o_adc_done is also an overrun;
//    the FSM is back in IDLE only the following cycle.
//  - Stray i_eoc/i_drdy in IDLE have no effect. eoc_seen clears on entry to CONV.
//  - Done pulses never merge: at least one IDLE cycle separates consecutive requests.
// TESTING
//  1 Reset: assert rst mid-WAIT_DRDY -> all outputs 0 same cycle, o_daddr=7'h16.
//    No done after release.
//  2 Nominal: trigger; eoc 3 cycles after convst falls; drdy 2 cycles after den;
//    i_do=16'hABC0 -> o_adc_val=12'hABC, single done pulse, convst high exactly 4 cycles.
//  3 Early EOC: eoc pulse during CONV -> READ entered right after CONV;
//    exactly one o_den pulse.
//  4 Timeout: never assert eoc -> after 1024 WAIT_EOC cycles, done=1 and timeout=1
//    together; o_adc_val keeps prior value 12'hABC.
//  5 Overrun: trigger again 2 cycles after first, and again on the done cycle
//    -> two o_overrun pulses, exactly one conversion.
//  6 Back-to-back: 100 triggers each issued the cycle after done, random eoc/drdy delays
//    -> 100 done pulses, values match model, zero overrun.

Source files
------------

// File: rtl/xadc_conv_sequencer.sv
// Sequences one XADC conversion per trigger: CONVST pulse, EOC wait, DRP read of the result register.
// Latency CONVST_WIDTH+4 cycles with prompt EOC/DRDY; no backpressure, triggers while busy are dropped and flagged.
module xadc_conv_sequencer #(
  parameter int         NB_DATA      = 12,
  parameter logic [6:0] DRP_ADDR     = 7'h16,
  parameter int         CONVST_WIDTH = 4,
  parameter int         TIMEOUT      = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_trigger,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_adc_val,
  output logic               o_adc_done,
  output logic               o_timeout,
  output logic               o_overrun,
  output logic               o_convst,
  input  logic               i_eoc,
  output logic               o_den,
  output logic [6:0]         o_daddr,
  output logic               o_dwe,
  input  logic               i_drdy,
  input  logic [15:0]        i_do
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CONV      = 3'd1;
  localparam logic [2:0] WAIT_EOC  = 3'd2;
  localparam logic [2:0] READ      = 3'd3;
  localparam logic [2:0] WAIT_DRDY = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  // One counter serves both the CONVST width and the EOC/DRDY timeouts.
  localparam int MAX_CNT = (TIMEOUT > CONVST_WIDTH) ? TIMEOUT : CONVST_WIDTH;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONVST_WIDTH - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             eoc_seen;
  logic             unused_do_bits;

  assign o_daddr        = DRP_ADDR;
  assign o_dwe          = 1'b0;
  assign unused_do_bits = ^i_do;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      eoc_seen   <= 1'b0;
      o_busy     <= 1'b0;
      o_adc_val  <= '0;
      o_adc_done <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
      o_convst   <= 1'b0;
      o_den      <= 1'b0;
    end else begin
      o_adc_done <= 1'b0;
      o_timeout  <= 1'b0;
      o_den      <= 1'b0;
      // DONE counts as busy, so a trigger on the done cycle is an overrun too.
      o_overrun  <= i_trigger && (state != IDLE);

      case (state)
        IDLE: begin
          if (i_trigger) begin
            state    <= CONV;
            o_convst <= 1'b1;
            o_busy   <= 1'b1;
            cnt      <= '0;
            eoc_seen <= 1'b0;
          end
        end

        CONV: begin
          if (i_eoc) eoc_seen <= 1'b1;
          if (cnt == CONV_LAST) begin
            o_convst <= 1'b0;
            cnt      <= '0;
            // EOC already seen during the pulse: skip straight to the DRP read.
            if (eoc_seen || i_eoc) begin
              state <= READ;
              o_den <= 1'b1;
            end else begin
              state <= WAIT_EOC;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_EOC: begin
          if (i_eoc || eoc_seen) begin
            state <= READ;
            o_den <= 1'b1;
          end else if (cnt == TMO_LAST) begin
            state      <= DONE;
            o_adc_done <= 1'b1;
            o_timeout  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // DRDY in the DEN cycle cannot belong to this read and is ignored.
        READ: begin
          state <= WAIT_DRDY;
          cnt   <= '0;
        end

        WAIT_DRDY: begin
          if (i_drdy) begin
            state      <= DONE;
            o_adc_val  <= i_do[15 -: NB_DATA];
            o_adc_done <= 1'b1;
          end else if (cnt == TMO_LAST) begin
            state      <= DONE;
            o_adc_done <= 1'b1;
            o_timeout  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          o_busy   <= 1'b0;
          o_convst <= 1'b0;
        end
      endcase
    end
  end

endmodule
